// File: rtl/morph_pkg.sv
// Shared definitions for the 3x3 morphology frame sequencer: mode encodings,
// FSM state type and default image geometry.
package morph_pkg;

    localparam logic [1:0] MODE_BYPASS = 2'd0;
    localparam logic [1:0] MODE_ERODE  = 2'd1;
    localparam logic [1:0] MODE_DILATE = 2'd2;

    localparam int IMG_W_DEF = 640;
    localparam int IMG_H_DEF = 480;

    localparam int WIN_CNT_W = 20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_ACTIVE,
        ST_DONE
    } state_t;

    // The reserved encoding falls back to bypass so the filter never sees it.
    function automatic logic [1:0] latch_mode(input logic [1:0] req);
        case (req)
            MODE_ERODE:  return MODE_ERODE;
            MODE_DILATE: return MODE_DILATE;
            default:     return MODE_BYPASS;
        endcase
    endfunction

endpackage

// File: rtl/morph_frame_ctrl.sv
// Frame/row/column sequencer and window-valid gating for the 3x3 morphology filter.
// Optional macro MORPH_CTRL_STATS_EN adds the per-frame oWIN_COUNT output.
module morph_frame_ctrl
    import morph_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int CW    = 10,
    parameter int RW    = 10
) (
    input  logic          CLOCK,
    input  logic          RESET_N,
    input  logic          iFVAL,
    input  logic          iDVAL,
    input  logic [1:0]    iMODE,
    output logic [1:0]    oMODE,
    output logic          oWIN_VALID,
    output logic [CW-1:0] oCOL,
    output logic [RW-1:0] oROW,
    output logic          oBUSY,
    output logic          oFRAME_DONE,
    output logic          oABORT,
    output logic          oOVERRUN
`ifdef MORPH_CTRL_STATS_EN
    ,
    output logic [WIN_CNT_W-1:0] oWIN_COUNT
`endif
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_fval_d;
    logic          r_rise_pend;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [1:0]    r_mode;
    logic          r_win_valid;
    logic [CW-1:0] r_win_col;
    logic [RW-1:0] r_win_row;
    logic          r_frame_done;
    logic          r_abort;
    logic          r_overrun;

    logic w_rise;
    logic w_start;
    logic w_in_frame;
    logic w_abort;
    logic w_pix;
    logic w_col_last;
    logic w_row_last;
    logic w_last_pix;
    logic w_prime_done;
    logic w_win_next;
    logic w_excess;

    assign w_rise       = iFVAL & ~r_fval_d;
    // A rise seen while in DONE is remembered so the next frame starts from IDLE.
    assign w_start      = (r_state == ST_IDLE) & (w_rise | r_rise_pend);
    assign w_in_frame   = (r_state == ST_PRIME) | (r_state == ST_ACTIVE);
    assign w_abort      = w_in_frame & ~iFVAL;
    assign w_pix        = w_in_frame & iFVAL & iDVAL;
    assign w_col_last   = (r_col == CW'(IMG_W - 1));
    assign w_row_last   = (r_row == RW'(IMG_H - 1));
    assign w_last_pix   = (r_state == ST_ACTIVE) & w_pix & w_col_last & w_row_last;
    assign w_prime_done = (r_state == ST_PRIME) & w_pix & w_col_last & (r_row == RW'(1));
    // ACTIVE implies row >= 2, so only the left border column needs masking here.
    assign w_win_next   = w_pix & (r_state == ST_ACTIVE) & (r_col >= CW'(2));
    assign w_excess     = iFVAL & iDVAL & ~w_rise
                        & ((r_state == ST_IDLE) | (r_state == ST_DONE));

    always_comb begin
        // NOTE: default first so every path assigns w_state_nxt and no latch is inferred.
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) w_state_nxt = ST_PRIME;
            end
            ST_PRIME: begin
                if (w_abort)           w_state_nxt = ST_IDLE;
                else if (w_prime_done) w_state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (w_abort)         w_state_nxt = ST_IDLE;
                else if (w_last_pix) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= ST_IDLE;
            r_fval_d    <= 1'b0;
            r_rise_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_fval_d    <= iFVAL;
            r_rise_pend <= (r_state == ST_DONE) & w_rise;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_start) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_pix) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // Window centre trails the incoming pixel by one column and one row.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_win_valid <= 1'b0;
            r_win_col   <= '0;
            r_win_row   <= '0;
        end else begin
            r_win_valid <= w_win_next;
            if (w_win_next) begin
                r_win_col <= r_col - CW'(1);
                r_win_row <= r_row - RW'(1);
            end
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_mode       <= MODE_BYPASS;
            r_frame_done <= 1'b0;
            r_abort      <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_done <= (r_state == ST_DONE);
            r_abort      <= w_abort;
            if (w_start) begin
                r_mode    <= latch_mode(iMODE);
                r_overrun <= 1'b0;
            end else if (w_excess) begin
                r_overrun <= 1'b1;
            end
        end
    end

`ifdef MORPH_CTRL_STATS_EN
    logic [WIN_CNT_W-1:0] r_win_cnt;
    logic [WIN_CNT_W-1:0] r_win_count;

    // The final window of a frame is still in flight during DONE, so it is folded in here.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_win_cnt   <= '0;
            r_win_count <= '0;
        end else begin
            if (w_start)          r_win_cnt <= '0;
            else if (r_win_valid) r_win_cnt <= r_win_cnt + WIN_CNT_W'(1);
            if (r_state == ST_DONE)
                r_win_count <= r_win_cnt + WIN_CNT_W'(r_win_valid);
        end
    end

    assign oWIN_COUNT = r_win_count;
`endif

    assign oMODE       = r_mode;
    assign oWIN_VALID  = r_win_valid;
    assign oCOL        = r_win_col;
    assign oROW        = r_win_row;
    assign oBUSY       = w_in_frame;
    assign oFRAME_DONE = r_frame_done;
    assign oABORT      = r_abort;
    assign oOVERRUN    = r_overrun;

endmodule

// File: doc/morph_frame_ctrl.md
Name: morph_frame_ctrl

Overview:
- Sequencer for the 3x3 morphology window (line buffer plus 9-pixel register array) in the camera pipeline.
- Tracks frame, row and column position from iFVAL/iDVAL.
- Gates window validity during line-buffer priming and at image borders.
- Latches the per-frame operation mode (bypass/erode/dilate) and reports frame completion, aborts and overruns to the downstream filter stage.

Parameters:
- IMG_W, 640, active pixels per line.
- IMG_H, 480, active lines per frame.
- CW, 10, column counter width (must satisfy 2^CW > IMG_W).
- RW, 10, row counter width (must satisfy 2^RW > IMG_H).

Ports:
- CLOCK  in  1  system clock, all logic rising-edge.
- RESET_N  in  1  asynchronous active-low reset.
- iFVAL  in  1  frame valid, high for the whole frame.
- iDVAL  in  1  pixel valid, one pixel per cycle when high.
- iMODE  in  2  requested operation: 0 bypass, 1 erode, 2 dilate, 3 reserved (treated as bypass).
- oMODE  out  2  mode latched for the current frame.
- oWIN_VALID  out  1  the 3x3 window is fully interior and its centre is a real pixel.
- oCOL  out  CW  centre column of the current window.
- oROW  out  RW  centre row of the current window.
- oBUSY  out  1  high in PRIME and ACTIVE states.
- oFRAME_DONE  out  1  one-cycle pulse when the frame completes normally.
- oABORT  out  1  one-cycle pulse when iFVAL falls mid-frame.
- oOVERRUN  out  1  sticky flag: excess pixels arrived after the last line.

Behaviour:
- Reset: state IDLE; all outputs 0; col and row counters 0; oMODE 0.
- iFVAL rising edge detected with a registered copy (rise = iFVAL & ~iFVAL_d).
- States: IDLE, PRIME, ACTIVE, DONE.
- IDLE:
  - On iFVAL rise: latch oMODE (iMODE 3 latches as 0), clear col, row and oOVERRUN, go to PRIME.
  - iDVAL while iFVAL high and no rise in the same cycle: set oOVERRUN.
- Column/row counting (PRIME and ACTIVE only):
  - col increments on each iDVAL.
  - At col == IMG_W-1 with iDVAL: col wraps to 0 and row increments.
  - Cycles without iDVAL hold both counters.
- PRIME -> ACTIVE when row wraps from 1 to 2 (the line buffer now holds two full lines).
- ACTIVE -> DONE when the last pixel (row IMG_H-1, col IMG_W-1) is accepted.
- DONE: pulse oFRAME_DONE for exactly one cycle, then go to IDLE.
- oWIN_VALID (registered, 1-cycle latency):
  - Next cycle = iDVAL & state==ACTIVE & col >= 2. Row >= 2 is implied by the ACTIVE state.
  - In the same cycle, oCOL = col-1 and oROW = row-1, taken from the pre-increment values.
  - When oWIN_VALID is low, oCOL and oROW hold their last values.
- Border rows 0 and IMG_H-1 and border columns 0 and IMG_W-1 never produce oWIN_VALID.
  - Per frame, exactly (IMG_W-2)*(IMG_H-2) valid windows are produced.
- iFVAL low while in PRIME or ACTIVE:
  - Pulse oABORT for one cycle and go to IDLE.
  - No oFRAME_DONE; oWIN_VALID forced 0 from the next cycle.
- iFVAL rise in the same cycle as DONE: the rise is registered and the new frame starts from IDLE on the following cycle. No frame is lost; the rise flag is held one extra cycle.
- oMODE is stable for the whole frame; iMODE changes mid-frame are ignored.
- Asynchronous reset mid-frame returns to the reset state immediately, with no pulses.

Optional Feature:
- Macro: MORPH_CTRL_STATS_EN.
- With the macro defined:
  - Adds output oWIN_COUNT[19:0], the count of oWIN_VALID assertions in the frame.
  - Internal counter clears on iFVAL rise.
  - oWIN_COUNT updates when oFRAME_DONE pulses and holds otherwise.
  - On abort, oWIN_COUNT is not updated.
  - Reset value 0.
- Without the macro: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package morph_pkg contains:
  - Mode encoding constants MODE_BYPASS=0, MODE_ERODE=1, MODE_DILATE=2.
  - State enum.
  - Default IMG_W and IMG_H constants.
- No sub-module; the counters and FSM form a single module.

Test Plan (bench uses IMG_W=8, IMG_H=6):
- Continuous frame, iMODE=1: 48 iDVAL cycles -> 24 oWIN_VALID pulses; first pulse has oCOL=1, oROW=1; last has oCOL=6, oROW=4; oFRAME_DONE one cycle after DONE entry; oMODE=1 throughout.
- iDVAL gaps: alternate iDVAL 1/0 for the same frame -> still 24 valid windows with identical coordinates; no valid output in gap cycles.
- Abort: drop iFVAL at row 3, col 4 -> oABORT pulse, no oFRAME_DONE, oWIN_VALID=0 afterwards, state IDLE.
- Overrun: 4 extra iDVAL cycles after the last pixel with iFVAL still high -> oOVERRUN=1, held until the next iFVAL rise, then cleared.
- Mode handling: iMODE=3 at frame start -> oMODE=0; change iMODE to 2 mid-frame -> oMODE stays 0; the next frame latches 2.
- Reset mid-ACTIVE: assert RESET_N=0 -> all outputs 0 asynchronously; a new frame after release behaves as in the first scenario. With MORPH_CTRL_STATS_EN, oWIN_COUNT=24 after a normal frame and is unchanged after an aborted one.
